mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning), in this order:
- clk_in  input  1  sole clock, rising edge.
- rst_in  input  1  reset, synchronous, active-low.
- valid_in  input  1  ex_mem latch holds a live instruction.
- cmdtype_in  input  6  command type from ex_mem (codebase Cmd encoding).
- rsd_addr_in  input  5  destination register.
- rsd_data_in  input  32  ALU result from EX.
- write_rsd_in  input  1  destination write requested.
- mem_addr_in  input  32  effective load/store address.
- store_data_in  input  32  store source value (rs2).
- mem_req_o  output  1  request to memory controller.
- mem_we_o  output  1  1 = store, 0 = load.
- mem_addr_o  output  32  access address.
- mem_wdata_o  output  32  store data, LSB-aligned.
- mem_len_o  output  2  00 = byte, 01 = half, 10 = word.
- mem_done_i  input  1  controller completion, one-cycle pulse.
- mem_rdata_i  input  32  load data, LSB-aligned, valid with mem_done_i.
- stall_o  output  1  freeze IF/ID/EX and ex_mem.
- rsd_addr_o  output  5  to mem_wb.
- rsd_data_o  output  32  to mem_wb.
- write_rsd_o  output  1  to mem_wb.
- fwd_en_o  output  1  forward valid to ID.
- fwd_addr_o  output  5  forwarded register.
- fwd_data_o  output  32  forwarded value.

Function
REQ-002 SHALL implement FSM states IDLE and BUSY.
REQ-003 In IDLE with valid_in=1 and a non-memory cmd: SHALL register rsd_addr_in, rsd_data_in and write_rsd_in onto the mem_wb outputs at the next edge (1-cycle latency); stall_o=0.
REQ-004 In IDLE with valid_in=1 and a load or store (LB/LH/LW/LBU/LHU/SB/SH/SW): SHALL drive stall_o=1 combinationally that cycle and enter BUSY at the next edge.
REQ-005 On entering BUSY, SHALL assert mem_req_o from that edge onward, with mem_we_o, mem_addr_o, mem_wdata_o and mem_len_o held stable until the cycle mem_done_i is sampled.
REQ-006 In BUSY: stall_o = !mem_done_i; valid_in and cmdtype_in SHALL be ignored.
REQ-007 On an edge where BUSY and mem_done_i=1: SHALL clear mem_req_o, return to IDLE, and update the mem_wb outputs.
- Load: write_rsd_o=1 and rsd_data_o = extended mem_rdata_i.
- Store: write_rsd_o=0.
REQ-008 Load extension: LB sign-extends bit 7; LBU zero-extends [7:0]; LH sign-extends bit 15; LHU zero-extends [15:0]; LW passes 32 bits.
REQ-009 mem_wdata_o SHALL be store_data_in[7:0] for SB and [15:0] for SH, zero-extended; SW passes all 32 bits.
REQ-010 rsd_addr 0 SHALL force write_rsd_o=0.
REQ-011 mem_done_i in IDLE SHALL be ignored.
REQ-012 valid_in=0 in IDLE SHALL register write_rsd_o=0 at the next edge.
REQ-013 Back-to-back memory ops SHALL incur one IDLE accept cycle each; no request overlap.

Reset
REQ-014 When rst_in=0 at an edge: state=IDLE, and mem_req_o, mem_we_o, write_rsd_o, fwd_en_o = 0; all data/address outputs = 0.
REQ-015 Reset during BUSY SHALL abort the access: mem_req_o low from that edge, no write-back.

Configuration
REQ-016 Macro MEM_FWD_EN defined: fwd_en_o = write_rsd_o && (rsd_addr_o != 0); fwd_addr_o = rsd_addr_o; fwd_data_o = rsd_data_o.
REQ-017 MEM_FWD_EN undefined: fwd_en_o, fwd_addr_o and fwd_data_o SHALL be tied to 0; all other behaviour unchanged.

Verification
REQ-018 ADD result: valid_in=1, cmd=ADD, rsd=5, data=0x1234, write=1 -> next cycle rsd_addr_o=5, rsd_data_o=0x1234, write_rsd_o=1, stall_o never high.
REQ-019 LB with sign extension: addr=0x100, done after 3 cycles, rdata=0x00000080 -> mem_len_o=00, mem_we_o=0, stall_o high 4 cycles, rsd_data_o=0xFFFFFF80.
REQ-020 SH: store_data=0xDEADBEEF, addr=0x200 -> mem_we_o=1, mem_len_o=01, mem_wdata_o=0x0000BEEF, write_rsd_o=0 after done.
REQ-021 Reset mid-access: rst_in=0 while BUSY -> mem_req_o=0 next edge, state IDLE, a later mem_done_i pulse causes no write.
REQ-022 Forward, x0 guard: LW to rd=0 with rdata=0x55 -> write_rsd_o=0, fwd_en_o=0; LW to rd=3 -> fwd_en_o=1, fwd_data_o=0x55 (MEM_FWD_EN defined) or 0 (undefined).

Source files
------------

// File: rtl/mem_access.sv
// MEM pipeline stage: forwards ALU results to mem_wb and runs one blocking load/store per memory op.
// Optional macro MEM_FWD_EN enables the MEM-to-ID forwarding outputs; when undefined they are tied to 0.
module mem_access (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic [5:0]  cmdtype_in,
    input  logic [4:0]  rsd_addr_in,
    input  logic [31:0] rsd_data_in,
    input  logic        write_rsd_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] store_data_in,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [1:0]  mem_len_o,
    input  logic        mem_done_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic [4:0]  rsd_addr_o,
    output logic [31:0] rsd_data_o,
    output logic        write_rsd_o,
    output logic        fwd_en_o,
    output logic [4:0]  fwd_addr_o,
    output logic [31:0] fwd_data_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Cmd encoding of the memory operations; every other code is an ALU-type result.
    localparam logic [5:0] CMD_LB  = 6'h10;
    localparam logic [5:0] CMD_LH  = 6'h11;
    localparam logic [5:0] CMD_LW  = 6'h12;
    localparam logic [5:0] CMD_LBU = 6'h13;
    localparam logic [5:0] CMD_LHU = 6'h14;
    localparam logic [5:0] CMD_SB  = 6'h18;
    localparam logic [5:0] CMD_SH  = 6'h19;
    localparam logic [5:0] CMD_SW  = 6'h1A;

    logic [0:0]  state_q,     state_d;
    logic        memReq_q,    memReq_d;
    logic        memWe_q,     memWe_d;
    logic [31:0] memAddr_q,   memAddr_d;
    logic [31:0] memWdata_q,  memWdata_d;
    logic [1:0]  memLen_q,    memLen_d;
    logic [5:0]  pendCmd_q,   pendCmd_d;
    logic [4:0]  pendRd_q,    pendRd_d;
    logic        pendLoad_q,  pendLoad_d;
    logic [4:0]  rsdAddr_q,   rsdAddr_d;
    logic [31:0] rsdData_q,   rsdData_d;
    logic        writeRsd_q,  writeRsd_d;

    logic isLoad;
    logic isStore;
    logic stall;

    assign isLoad  = (cmdtype_in == CMD_LB) || (cmdtype_in == CMD_LH) || (cmdtype_in == CMD_LW) ||
                     (cmdtype_in == CMD_LBU) || (cmdtype_in == CMD_LHU);
    assign isStore = (cmdtype_in == CMD_SB) || (cmdtype_in == CMD_SH) || (cmdtype_in == CMD_SW);

    function automatic logic [31:0] extendLoad(input logic [5:0] cmd, input logic [31:0] raw);
        logic [31:0] res;
        res = raw;
        case (cmd)
            CMD_LB:  res = {{24{raw[7]}}, raw[7:0]};
            CMD_LBU: res = {24'd0, raw[7:0]};
            CMD_LH:  res = {{16{raw[15]}}, raw[15:0]};
            CMD_LHU: res = {16'd0, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    always_comb begin
        state_d    = state_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        memLen_d   = memLen_q;
        pendCmd_d  = pendCmd_q;
        pendRd_d   = pendRd_q;
        pendLoad_d = pendLoad_q;
        rsdAddr_d  = rsdAddr_q;
        rsdData_d  = rsdData_q;
        writeRsd_d = writeRsd_q;
        stall      = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in && (isLoad || isStore)) begin
                    stall      = 1'b1;
                    state_d    = BUSY;
                    memReq_d   = 1'b1;
                    memWe_d    = isStore;
                    memAddr_d  = mem_addr_in;
                    memWdata_d = 32'd0;
                    memLen_d   = 2'b10;
                    case (cmdtype_in)
                        CMD_LB, CMD_LBU: memLen_d = 2'b00;
                        CMD_LH, CMD_LHU: memLen_d = 2'b01;
                        CMD_SB: begin memLen_d = 2'b00; memWdata_d = {24'd0, store_data_in[7:0]}; end
                        CMD_SH: begin memLen_d = 2'b01; memWdata_d = {16'd0, store_data_in[15:0]}; end
                        CMD_SW: memWdata_d = store_data_in;
                        default: memLen_d = 2'b10;
                    endcase
                    pendCmd_d  = cmdtype_in;
                    pendRd_d   = rsd_addr_in;
                    pendLoad_d = isLoad;
                    writeRsd_d = 1'b0;
                end else if (valid_in) begin
                    rsdAddr_d  = rsd_addr_in;
                    rsdData_d  = rsd_data_in;
                    writeRsd_d = write_rsd_in && (rsd_addr_in != 5'd0);
                end else begin
                    writeRsd_d = 1'b0;
                end
            end
            BUSY: begin
                // mem_wb sees bubbles until the access completes; completion is the write-back.
                stall      = !mem_done_i;
                writeRsd_d = 1'b0;
                if (mem_done_i) begin
                    state_d    = IDLE;
                    memReq_d   = 1'b0;
                    rsdAddr_d  = pendRd_q;
                    rsdData_d  = pendLoad_q ? extendLoad(pendCmd_q, mem_rdata_i) : 32'd0;
                    writeRsd_d = pendLoad_q && (pendRd_q != 5'd0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= 32'd0;
            memWdata_q <= 32'd0;
            memLen_q   <= 2'b00;
            pendCmd_q  <= 6'd0;
            pendRd_q   <= 5'd0;
            pendLoad_q <= 1'b0;
            rsdAddr_q  <= 5'd0;
            rsdData_q  <= 32'd0;
            writeRsd_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            memLen_q   <= memLen_d;
            pendCmd_q  <= pendCmd_d;
            pendRd_q   <= pendRd_d;
            pendLoad_q <= pendLoad_d;
            rsdAddr_q  <= rsdAddr_d;
            rsdData_q  <= rsdData_d;
            writeRsd_q <= writeRsd_d;
        end
    end

    assign mem_req_o   = memReq_q;
    assign mem_we_o    = memWe_q;
    assign mem_addr_o  = memAddr_q;
    assign mem_wdata_o = memWdata_q;
    assign mem_len_o   = memLen_q;
    assign stall_o     = stall;
    assign rsd_addr_o  = rsdAddr_q;
    assign rsd_data_o  = rsdData_q;
    assign write_rsd_o = writeRsd_q;

`ifdef MEM_FWD_EN
    assign fwd_en_o   = writeRsd_q && (rsdAddr_q != 5'd0);
    assign fwd_addr_o = rsdAddr_q;
    assign fwd_data_o = rsdData_q;
`else
    assign fwd_en_o   = 1'b0;
    assign fwd_addr_o = 5'd0;
    assign fwd_data_o = 32'd0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access against a transaction-level reference model.
// Honors MEM_FWD_EN the same way the design does.
module tb_mem_access;

    localparam logic [5:0] CMD_ADD = 6'h01;
    localparam logic [5:0] CMD_SUB = 6'h02;
    localparam logic [5:0] CMD_LB  = 6'h10;
    localparam logic [5:0] CMD_LH  = 6'h11;
    localparam logic [5:0] CMD_LW  = 6'h12;
    localparam logic [5:0] CMD_LBU = 6'h13;
    localparam logic [5:0] CMD_LHU = 6'h14;
    localparam logic [5:0] CMD_SB  = 6'h18;
    localparam logic [5:0] CMD_SH  = 6'h19;
    localparam logic [5:0] CMD_SW  = 6'h1A;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        valid_in;
    logic [5:0]  cmdtype_in;
    logic [4:0]  rsd_addr_in;
    logic [31:0] rsd_data_in;
    logic        write_rsd_in;
    logic [31:0] mem_addr_in;
    logic [31:0] store_data_in;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [1:0]  mem_len_o;
    logic        mem_done_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic [4:0]  rsd_addr_o;
    logic [31:0] rsd_data_o;
    logic        write_rsd_o;
    logic        fwd_en_o;
    logic [4:0]  fwd_addr_o;
    logic [31:0] fwd_data_o;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .cmdtype_in(cmdtype_in),
        .rsd_addr_in(rsd_addr_in), .rsd_data_in(rsd_data_in), .write_rsd_in(write_rsd_in),
        .mem_addr_in(mem_addr_in), .store_data_in(store_data_in),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_len_o(mem_len_o),
        .mem_done_i(mem_done_i), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o),
        .rsd_addr_o(rsd_addr_o), .rsd_data_o(rsd_data_o), .write_rsd_o(write_rsd_o),
        .fwd_en_o(fwd_en_o), .fwd_addr_o(fwd_addr_o), .fwd_data_o(fwd_data_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit isLoadCmd(input logic [5:0] c);
        return c == CMD_LB || c == CMD_LH || c == CMD_LW || c == CMD_LBU || c == CMD_LHU;
    endfunction

    function automatic bit isStoreCmd(input logic [5:0] c);
        return c == CMD_SB || c == CMD_SH || c == CMD_SW;
    endfunction

    function automatic int accessBytes(input logic [5:0] c);
        if (c == CMD_LB || c == CMD_LBU || c == CMD_SB) return 1;
        if (c == CMD_LH || c == CMD_LHU || c == CMD_SH) return 2;
        return 4;
    endfunction

    // Value a load delivers to the register file, computed arithmetically from the access width.
    function automatic logic [31:0] modelLoad(input logic [5:0] c, input logic [31:0] raw);
        longint v;
        longint span;
        int n;
        n = accessBytes(c);
        if (n == 4) return raw;
        span = longint'(1) << (8 * n);
        v = longint'(raw) % span;
        if ((c == CMD_LB || c == CMD_LH) && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    function automatic logic [31:0] modelWdata(input logic [5:0] c, input logic [31:0] src);
        longint span;
        span = longint'(1) << (8 * accessBytes(c));
        return 32'(longint'(src) % span);
    endfunction

    task automatic checkFwd(input bit expWr, input logic [4:0] rd, input logic [31:0] expData);
`ifdef MEM_FWD_EN
        checkOutput("fwdEn", fwd_en_o, expWr);
        checkOutput("fwdAddr", fwd_addr_o, rd);
        if (expWr) checkOutput("fwdData", fwd_data_o, expData);
`else
        checkOutput("fwdEn", fwd_en_o, 0);
        checkOutput("fwdAddr", fwd_addr_o, 0);
        checkOutput("fwdData", fwd_data_o, 0);
`endif
    endtask

    // Issues one instruction; entered and left at posedge+1.
    task automatic applyStimulus(input logic [5:0] cmd, input logic [4:0] rd, input logic [31:0] data,
                                 input logic wr, input logic [31:0] addr, input logic [31:0] sdata,
                                 input int latency, input logic [31:0] rdata);
        int stallCount;
        bit expWr;
        logic [31:0] expData;
        valid_in = 1'b1; cmdtype_in = cmd; rsd_addr_in = rd; rsd_data_in = data;
        write_rsd_in = wr; mem_addr_in = addr; store_data_in = sdata;
        #1;
        stallCount = 0;
        if (isLoadCmd(cmd) || isStoreCmd(cmd)) begin
            checkOutput("stallAccept", stall_o, 1);
            if (stall_o) stallCount++;
            @(posedge clk); #1;
            valid_in = 1'($urandom); cmdtype_in = 6'($urandom);
            mem_addr_in = $urandom; store_data_in = $urandom; rsd_addr_in = 5'($urandom);
            checkOutput("memReq", mem_req_o, 1);
            checkOutput("memWe", mem_we_o, isStoreCmd(cmd));
            checkOutput("memAddr", mem_addr_o, addr);
            checkOutput("memLen", mem_len_o, accessBytes(cmd) == 1 ? 0 : accessBytes(cmd) == 2 ? 1 : 2);
            if (isStoreCmd(cmd)) checkOutput("memWdata", mem_wdata_o, modelWdata(cmd, sdata));
            for (int i = 0; i < latency; i++) begin
                #1;
                if (stall_o) stallCount++;
                @(posedge clk); #1;
                checkOutput("reqHeld", mem_req_o, 1);
                checkOutput("addrHeld", mem_addr_o, addr);
                checkOutput("wbBubble", write_rsd_o, 0);
            end
            mem_done_i = 1'b1; mem_rdata_i = rdata;
            #1;
            if (stall_o) stallCount++;
            checkOutput("stallDone", stall_o, 0);
            @(posedge clk); #1;
            mem_done_i = 1'b0; valid_in = 1'b0; mem_rdata_i = $urandom;
            checkOutput("reqCleared", mem_req_o, 0);
            checkOutput("stallCycles", stallCount, latency + 1);
            expWr = isLoadCmd(cmd) && rd != 0;
            expData = modelLoad(cmd, rdata);
            checkOutput("wbWrite", write_rsd_o, expWr);
            checkOutput("wbAddr", rsd_addr_o, rd);
            if (isLoadCmd(cmd)) checkOutput("wbLoadData", rsd_data_o, expData);
        end else begin
            checkOutput("stallAlu", stall_o, 0);
            @(posedge clk); #1;
            valid_in = 1'b0;
            expWr = wr && rd != 0;
            expData = data;
            checkOutput("aluWrite", write_rsd_o, expWr);
            checkOutput("aluAddr", rsd_addr_o, rd);
            checkOutput("aluData", rsd_data_o, data);
        end
        checkFwd(expWr, rd, expData);
    endtask

    logic [5:0] cmdList [10] = '{CMD_ADD, CMD_SUB, CMD_LB, CMD_LH, CMD_LW,
                                 CMD_LBU, CMD_LHU, CMD_SB, CMD_SH, CMD_SW};

    initial begin
        rst_in = 1'b0; valid_in = 1'b0; cmdtype_in = 6'd0; rsd_addr_in = 5'd0; rsd_data_in = 32'd0;
        write_rsd_in = 1'b0; mem_addr_in = 32'd0; store_data_in = 32'd0;
        mem_done_i = 1'b0; mem_rdata_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstReq", mem_req_o, 0);
        checkOutput("rstWe", mem_we_o, 0);
        checkOutput("rstWrite", write_rsd_o, 0);
        checkOutput("rstAddr", mem_addr_o, 0);
        checkOutput("rstData", rsd_data_o, 0);
        checkOutput("rstFwd", fwd_en_o, 0);
        rst_in = 1'b1;
        @(posedge clk); #1;

        applyStimulus(CMD_ADD, 5'd5, 32'h1234, 1'b1, 32'h0, 32'h0, 0, 32'h0);
        applyStimulus(CMD_LB, 5'd9, 32'h0, 1'b1, 32'h100, 32'h0, 3, 32'h0000_0080);
        applyStimulus(CMD_SH, 5'd4, 32'h0, 1'b0, 32'h200, 32'hDEAD_BEEF, 2, 32'h0);
        applyStimulus(CMD_LW, 5'd0, 32'h0, 1'b1, 32'h300, 32'h0, 1, 32'h55);
        applyStimulus(CMD_LW, 5'd3, 32'h0, 1'b1, 32'h304, 32'h0, 1, 32'h55);

        // Stray completion while idle must not write back.
        mem_done_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mem_done_i = 1'b0;
        checkOutput("idleDoneWrite", write_rsd_o, 0);
        checkOutput("idleDoneReq", mem_req_o, 0);

        // Reset in the middle of a load aborts it.
        valid_in = 1'b1; cmdtype_in = CMD_LW; rsd_addr_in = 5'd7; mem_addr_in = 32'h400;
        @(posedge clk); #1;
        valid_in = 1'b0;
        checkOutput("abortReqBefore", mem_req_o, 1);
        rst_in = 1'b0;
        @(posedge clk); #1;
        checkOutput("abortReq", mem_req_o, 0);
        checkOutput("abortWrite", write_rsd_o, 0);
        checkOutput("abortStall", stall_o, 0);
        rst_in = 1'b1;
        @(posedge clk); #1;
        mem_done_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        @(posedge clk); #1;
        mem_done_i = 1'b0;
        checkOutput("abortLateDoneWrite", write_rsd_o, 0);
        checkOutput("abortLateDoneReq", mem_req_o, 0);

        for (int n = 0; n < 60; n++) begin
            applyStimulus(cmdList[$urandom_range(0, 9)], 5'($urandom), $urandom, 1'($urandom),
                          $urandom, $urandom, $urandom_range(0, 4), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                checkOutput("gapWrite", write_rsd_o, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
